// File: rtl/mux4_arb_pkg.sv
// mux4_arb_pkg: shared types for the 4-requester round-robin arbiter.
// Holds the FSM state enum, the requester count and the 2-bit index type.
package mux4_arb_pkg;

  localparam int NREQ = 4;

  typedef logic [1:0] idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Next index in round-robin order; wraps 3 -> 0 through 2-bit overflow.
  function automatic idx_t idx_inc(input idx_t i);
    return i + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational round-robin priority picker.
// Returns the first valid requester at or after rr_ptr_i, wrapping 3 -> 0.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [3:0] req_valid_i,
  input  idx_t       rr_ptr_i,
  output idx_t       idx_o,
  output logic       any_o
);

  logic found;
  idx_t cand;

  // Scan the four candidates starting at the pointer; the first hit wins.
  always_comb begin
    idx_o = rr_ptr_i;
    any_o = |req_valid_i;
    found = 1'b0;
    cand  = rr_ptr_i;
    for (int k = 0; k < NREQ; k++) begin
      cand = rr_ptr_i + idx_t'(k);
      if (!found && req_valid_i[cand]) begin
        idx_o = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: 4:1 packet multiplexer with round-robin arbitration.
// A grant is held for a whole packet (until a handshake with out_last);
// one idle cycle separates packets. The datapath is a pure combinational
// mux steered by the registered select.
// Optional watchdog: define MUX4_ARB_WATCHDOG_EN to abort a grant that sees
// no handshake for TIMEOUT cycles (timeout_err pulses once on abort).
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req_valid,
  input  logic [4*DW-1:0] req_data,
  input  logic [3:0]      req_last,
  output logic [3:0]      req_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  input  logic            out_ready,
  output logic [1:0]      sel,
  output logic            busy,
  output logic            timeout_err
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
    $error("mux4_rr_arbiter: TIMEOUT must be in 2..255");
  end

  state_t state_q, state_d;
  idx_t   rr_ptr_q, rr_ptr_d;
  idx_t   sel_q, sel_d;

  idx_t   pick_idx;
  logic   pick_any;
  logic   granted;
  logic   hs;
  logic   wd_fire;

  rr_pick4 u_pick (
    .req_valid_i (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .idx_o       (pick_idx),
    .any_o       (pick_any)
  );

  assign granted   = (state_q == GRANT);
  assign out_valid = granted && req_valid[sel_q];
  assign out_last  = granted && req_last[sel_q];
  assign hs        = out_valid && out_ready;
  assign sel       = sel_q;
  assign busy      = granted;

  // Only the granted requester sees out_ready; everyone else is held off.
  always_comb begin
    req_ready = '0;
    if (granted) begin
      req_ready[sel_q] = out_ready;
    end
  end

  // Shared payload mux, steered only by the registered select.
  always_comb begin
    case (sel_q)
      2'd0:    out_data = req_data[0*DW +: DW];
      2'd1:    out_data = req_data[1*DW +: DW];
      2'd2:    out_data = req_data[2*DW +: DW];
      default: out_data = req_data[3*DW +: DW];
    endcase
  end

`ifdef MUX4_ARB_WATCHDOG_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wd_cnt_q, wd_cnt_d;
  logic       tmo_q, tmo_d;

  // Count stalled grant cycles; fire when this cycle would reach TIMEOUT.
  always_comb begin
    wd_cnt_d = '0;
    tmo_d    = 1'b0;
    wd_fire  = 1'b0;
    if (granted && !hs) begin
      if (wd_cnt_q == WD_LAST) begin
        wd_fire = 1'b1;
        tmo_d   = 1'b1;
      end else begin
        wd_cnt_d = wd_cnt_q + 8'd1;
      end
    end
  end

  // Watchdog counter and one-cycle abort pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
      tmo_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      tmo_q    <= tmo_d;
    end
  end

  assign timeout_err = tmo_q;
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state: arbitrate in IDLE, release the grant on the last beat or abort.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          sel_d   = pick_idx;
        end
      end
      GRANT: begin
        if ((hs && out_last) || wd_fire) begin
          state_d  = IDLE;
          rr_ptr_d = idx_inc(sel_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; reset restores requester 0 as highest priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
    end
  end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 SHALL have parameter DW, default 8, per-requester payload width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 16, watchdog limit in cycles (range 2..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  4  per-requester valid; bit i belongs to requester i.
REQ-006 SHALL have port req_data  input  4*DW  requester i payload occupies bits [i*DW +: DW].
REQ-007 SHALL have port req_last  input  4  per-requester end-of-packet marker.
REQ-008 SHALL have port req_ready  output  4  per-requester ready; at most one bit high at any time.
REQ-009 SHALL have port out_valid  output  1  shared output valid.
REQ-010 SHALL have port out_data  output  DW  shared output payload.
REQ-011 SHALL have port out_last  output  1  shared output end-of-packet.
REQ-012 SHALL have port out_ready  input  1  downstream ready.
REQ-013 SHALL have port sel  output  2  registered select driving the 4:1 datapath mux; equals the granted index.
REQ-014 SHALL have port busy  output  1  high while in GRANT.
REQ-015 SHALL have port timeout_err  output  1  one-cycle pulse on a watchdog abort.

Function
REQ-016 SHALL implement FSM states IDLE and GRANT.
REQ-017 In IDLE, when req_valid != 0, SHALL pick the first valid index at or after rr_ptr (wrapping 3->0), load sel, and enter GRANT on the next edge; arbitration latency is 1 cycle.
REQ-018 In IDLE: out_valid=0, req_ready=0, busy=0.
REQ-019 In GRANT: out_valid=req_valid[sel], out_data=req_data[sel], out_last=req_last[sel], req_ready[sel]=out_ready, all other req_ready bits 0 (combinational pass-through, zero added latency).
REQ-020 A handshake occurs when out_valid && out_ready are high in GRANT.
REQ-021 Handshake with out_last=1 SHALL return to IDLE and set rr_ptr=(sel+1) mod 4; one bubble cycle separates packets.
REQ-022 Grant SHALL be held for the whole packet, even if req_valid[sel] drops mid-packet; no other requester is served meanwhile.
REQ-023 sel SHALL change only on the IDLE->GRANT transition.
REQ-024 With all four requesters continuously valid, grants SHALL rotate in strict order 0,1,2,3,0,...
REQ-025 In IDLE with req_valid=0, state, rr_ptr and sel SHALL hold.

Reset
REQ-026 On rst_n=0 at a clock edge: state=IDLE, rr_ptr=0, sel=0, watchdog count=0, timeout_err=0.
REQ-027 Reset mid-packet SHALL abandon the packet silently; no outputs assert in the reset cycle's following state beyond IDLE values.
REQ-028 After reset, requester 0 SHALL have highest priority.

Configuration
REQ-029 Macro MUX4_ARB_WATCHDOG_EN SHALL gate the watchdog.
REQ-030 With MUX4_ARB_WATCHDOG_EN defined: in GRANT, an 8-bit counter increments each cycle without a handshake and clears on a handshake; on reaching TIMEOUT the block returns to IDLE, sets rr_ptr=(sel+1) mod 4, and pulses timeout_err for exactly one cycle.
REQ-031 Without MUX4_ARB_WATCHDOG_EN: no counter is built, timeout_err is tied 0, and a stalled grant is held indefinitely.

Structure
REQ-032 Shared package mux4_arb_pkg SHALL hold the state enum (IDLE, GRANT), the requester-count constant 4, and the index type (2 bits).
REQ-033 Sub-module rr_pick4 SHALL be the combinational priority picker (inputs req_valid and rr_ptr, outputs index and any-valid); no other sub-modules.

Verification
REQ-034 Reset, then req_valid=4'b0100 -> sel=2 and busy=1 one cycle later; req_ready=4'b0100 while out_ready=1.
REQ-035 req_valid=4'b1111, every beat last=1, out_ready=1 -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-036 Requester 1 sends a 3-beat packet while requester 3 is valid throughout -> three beats from requester 1 reach out_data in order before sel changes to 3.
REQ-037 Watchdog build, TIMEOUT=16, grant to requester 0, out_ready=0 for 16 cycles -> timeout_err pulses once, busy drops, next grant goes to requester 1 if valid.
REQ-038 rst_n=0 mid-packet on requester 2 -> next cycle busy=0, sel=0, req_ready=0; next arbitration starts from requester 0.
